// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the memory-stage store sequencer.
package rv32i_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } rmw_state_e;

endpackage

// File: rtl/store_rmw_unit_if.sv
// MEM-stage bus: EX/MEM store/load operands in, word-wide data-memory port out.
interface store_rmw_unit_if #(
    parameter int ADDR_W = 32
);
    logic              EX_MEM_memwrite;
    logic              EX_MEM_memread;
    logic [2:0]        EX_MEM_funct3;
    logic [ADDR_W-1:0] EX_MEM_addr;
    logic [31:0]       EX_MEM_wdata;
    logic [31:0]       mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic              mem_write_bh;

    modport master (
        output EX_MEM_memwrite, EX_MEM_memread, EX_MEM_funct3, EX_MEM_addr, EX_MEM_wdata,
        output mem_rdata,
        input  mem_addr, mem_re, mem_we, mem_wdata, mem_write_bh
    );

    modport slave (
        input  EX_MEM_memwrite, EX_MEM_memread, EX_MEM_funct3, EX_MEM_addr, EX_MEM_wdata,
        input  mem_rdata,
        output mem_addr, mem_re, mem_we, mem_wdata, mem_write_bh
    );
endinterface

// File: rtl/byte_merge.sv
// Combinational lane merge: inserts SB/SH store data into the word read back from memory.
module byte_merge
    import rv32i_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    output logic [31:0] merged
);

    always_comb begin
        merged = new_data;
        case (funct3)
            F3_SB: begin
                merged = old_word;
                case (byte_off)
                    2'd0:    merged[7:0]   = new_data[7:0];
                    2'd1:    merged[15:8]  = new_data[7:0];
                    2'd2:    merged[23:16] = new_data[7:0];
                    default: merged[31:24] = new_data[7:0];
                endcase
            end
            F3_SH: begin
                // byte_off[0] is deliberately ignored: misaligned halfwords are not trapped.
                merged = old_word;
                if (byte_off[1]) merged[31:16] = new_data[15:0];
                else             merged[15:0]  = new_data[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/store_rmw_unit.sv
// Store sequencer: SB/SH become read-modify-write of the containing word with a pipeline stall;
// SW and loads go straight to the word-wide memory.
module store_rmw_unit
    import rv32i_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    store_rmw_unit_if.slave  bus
);

    rmw_state_e  state_q, state_d;
    logic [31:0] wbuf_q, wbuf_d;
    logic [31:0] merged;
    logic        req_bh;

    assign req_bh = bus.EX_MEM_memwrite &&
                    (bus.EX_MEM_funct3 == F3_SB || bus.EX_MEM_funct3 == F3_SH);

    assign bus.mem_addr = {bus.EX_MEM_addr[ADDR_W-1:2], 2'b00};

    byte_merge u_merge (
        .old_word (bus.mem_rdata),
        .new_data (bus.EX_MEM_wdata),
        .funct3   (bus.EX_MEM_funct3),
        .byte_off (bus.EX_MEM_addr[1:0]),
        .merged   (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            wbuf_q  <= wbuf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wbuf_d  = wbuf_q;
        case (state_q)
            IDLE:    if (req_bh) state_d = RD;
            RD: begin
                wbuf_d  = merged;
                state_d = WR;
            end
            // The store still held in EX/MEM during WR is the one just written; never retrigger.
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_re       = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_wdata    = '0;
        bus.mem_write_bh = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_bh) begin
                    bus.mem_re       = 1'b1;
                    bus.mem_write_bh = 1'b1;
                end else if (bus.EX_MEM_memwrite) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_wdata = bus.EX_MEM_wdata;
                end else begin
                    bus.mem_re = bus.EX_MEM_memread;
                end
            end
            RD:  bus.mem_write_bh = 1'b1;
            WR: begin
                bus.mem_we    = 1'b1;
                bus.mem_wdata = wbuf_q;
            end
            default: ;
        endcase
        // Strobes must be quiet the moment reset asserts, not only after the next edge.
        if (!rst_n) begin
            bus.mem_re       = 1'b0;
            bus.mem_we       = 1'b0;
            bus.mem_wdata    = '0;
            bus.mem_write_bh = 1'b0;
        end
    end

endmodule

// File: tb/tb_store_rmw_unit.sv
// Directed bench for store_rmw_unit with a word-wide synchronous memory model.
module tb_store_rmw_unit;
    import rv32i_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    store_rmw_unit_if #(.ADDR_W(32)) bus ();

    store_rmw_unit #(.ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:255];
    logic        pre_en = 1'b0;
    logic [7:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;
    int          we_cnt = 0;
    int          both_cnt = 0;

    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_data;
        else if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[9:2]];
        if (bus.mem_we) we_cnt <= we_cnt + 1;
    end

    always @(negedge clk) if (bus.mem_re && bus.mem_we) both_cnt <= both_cnt + 1;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic r, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        bus.EX_MEM_memwrite = w;
        bus.EX_MEM_memread  = r;
        bus.EX_MEM_funct3   = f3;
        bus.EX_MEM_addr     = a;
        bus.EX_MEM_wdata    = d;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 1'b0, F3_SW, 32'h0, 32'h0);
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pre_idx  = a[9:2];
        pre_data = d;
        pre_en   = 1'b1;
        next_cycle();
        pre_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b1, F3_SB, 32'h103, 32'hFFFF_FFFF);
        #3;
        checks++; if (bus.mem_re !== 1'b0) begin errors++; $display("FAIL rst_re: got %0b want 0", bus.mem_re); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %0b want 0", bus.mem_we); end
        checks++; if (bus.mem_write_bh !== 1'b0) begin errors++; $display("FAIL rst_bh: got %0b want 0", bus.mem_write_bh); end
        checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", bus.mem_wdata); end
        next_cycle();
        next_cycle();
        idle_inputs();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_sb();
        preload(32'h100, 32'h1122_3344);
        drive(1'b1, 1'b0, F3_SB, 32'h103, 32'hAABB_CC5A);
        #2;
        checks++; if (bus.mem_write_bh !== 1'b1) begin errors++; $display("FAIL sb_bh_c0: got %0b want 1", bus.mem_write_bh); end
        checks++; if (bus.mem_re !== 1'b1) begin errors++; $display("FAIL sb_re_c0: got %0b want 1", bus.mem_re); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL sb_we_c0: got %0b want 0", bus.mem_we); end
        checks++; if (bus.mem_addr !== 32'h100) begin errors++; $display("FAIL sb_addr: got %h want 00000100", bus.mem_addr); end
        next_cycle();
        #2;
        checks++; if (bus.mem_write_bh !== 1'b1) begin errors++; $display("FAIL sb_bh_c1: got %0b want 1", bus.mem_write_bh); end
        checks++; if (bus.mem_re !== 1'b0) begin errors++; $display("FAIL sb_re_c1: got %0b want 0", bus.mem_re); end
        next_cycle();
        #2;
        checks++; if (bus.mem_write_bh !== 1'b0) begin errors++; $display("FAIL sb_bh_c2: got %0b want 0", bus.mem_write_bh); end
        checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL sb_we_c2: got %0b want 1", bus.mem_we); end
        checks++; if (bus.mem_wdata !== 32'h5A22_3344) begin errors++; $display("FAIL sb_wdata: got %h want 5a223344", bus.mem_wdata); end
        next_cycle();
        idle_inputs();
        #2;
        checks++; if (mem[8'h40] !== 32'h5A22_3344) begin errors++; $display("FAIL sb_mem: got %h want 5a223344", mem[8'h40]); end
    endtask

    task automatic test_sh();
        preload(32'h200, 32'hDEAD_C0DE);
        drive(1'b1, 1'b0, F3_SH, 32'h202, 32'h0000_BEEF);
        #2;
        checks++; if (bus.mem_write_bh !== 1'b1) begin errors++; $display("FAIL sh_bh_c0: got %0b want 1", bus.mem_write_bh); end
        next_cycle();
        next_cycle();
        #2;
        checks++; if (bus.mem_wdata !== 32'hBEEF_C0DE) begin errors++; $display("FAIL sh_hi_wdata: got %h want beefc0de", bus.mem_wdata); end
        checks++; if (bus.mem_addr !== 32'h200) begin errors++; $display("FAIL sh_addr: got %h want 00000200", bus.mem_addr); end
        next_cycle();
        idle_inputs();
        preload(32'h200, 32'hDEAD_C0DE);
        drive(1'b1, 1'b0, F3_SH, 32'h201, 32'h0000_BEEF);
        next_cycle();
        next_cycle();
        #2;
        checks++; if (bus.mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sh_lo_wdata: got %h want deadbeef", bus.mem_wdata); end
        next_cycle();
        idle_inputs();
        #2;
        checks++; if (mem[8'h80] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sh_mem: got %h want deadbeef", mem[8'h80]); end
    endtask

    task automatic test_sw();
        drive(1'b1, 1'b0, F3_SW, 32'h300, 32'h1234_5678);
        #2;
        checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL sw_we: got %0b want 1", bus.mem_we); end
        checks++; if (bus.mem_wdata !== 32'h1234_5678) begin errors++; $display("FAIL sw_wdata: got %h want 12345678", bus.mem_wdata); end
        checks++; if (bus.mem_write_bh !== 1'b0) begin errors++; $display("FAIL sw_bh: got %0b want 0", bus.mem_write_bh); end
        checks++; if (bus.mem_re !== 1'b0) begin errors++; $display("FAIL sw_re: got %0b want 0", bus.mem_re); end
        next_cycle();
        drive(1'b1, 1'b0, 3'b111, 32'h304, 32'hCAFE_F00D);
        #2;
        checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL sw_f3other_we: got %0b want 1", bus.mem_we); end
        checks++; if (bus.mem_write_bh !== 1'b0) begin errors++; $display("FAIL sw_f3other_bh: got %0b want 0", bus.mem_write_bh); end
        next_cycle();
        idle_inputs();
        #2;
        checks++; if (mem[8'hC0] !== 32'h1234_5678) begin errors++; $display("FAIL sw_mem0: got %h want 12345678", mem[8'hC0]); end
        checks++; if (mem[8'hC1] !== 32'hCAFE_F00D) begin errors++; $display("FAIL sw_mem1: got %h want cafef00d", mem[8'hC1]); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL sw_idle_we: got %0b want 0", bus.mem_we); end
        next_cycle();
    endtask

    task automatic test_load();
        drive(1'b0, 1'b1, F3_SW, 32'h182, 32'h0);
        #2;
        checks++; if (bus.mem_re !== 1'b1) begin errors++; $display("FAIL ld_re: got %0b want 1", bus.mem_re); end
        checks++; if (bus.mem_write_bh !== 1'b0) begin errors++; $display("FAIL ld_bh: got %0b want 0", bus.mem_write_bh); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL ld_we: got %0b want 0", bus.mem_we); end
        checks++; if (bus.mem_addr !== 32'h180) begin errors++; $display("FAIL ld_addr: got %h want 00000180", bus.mem_addr); end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        preload(32'h100, 32'h0);
        drive(1'b1, 1'b0, F3_SB, 32'h103, 32'h0000_00AB);
        next_cycle();
        next_cycle();
        #2;
        checks++; if (bus.mem_wdata !== 32'hAB00_0000) begin errors++; $display("FAIL b2b_wdata1: got %h want ab000000", bus.mem_wdata); end
        next_cycle();
        drive(1'b1, 1'b0, F3_SB, 32'h102, 32'h0000_00CD);
        #2;
        checks++; if (bus.mem_write_bh !== 1'b1) begin errors++; $display("FAIL b2b_bh_issue2: got %0b want 1", bus.mem_write_bh); end
        checks++; if (bus.mem_re !== 1'b1) begin errors++; $display("FAIL b2b_re_issue2: got %0b want 1", bus.mem_re); end
        next_cycle();
        next_cycle();
        #2;
        checks++; if (bus.mem_wdata !== 32'hABCD_0000) begin errors++; $display("FAIL b2b_wdata2: got %h want abcd0000", bus.mem_wdata); end
        next_cycle();
        idle_inputs();
        #2;
        checks++; if (mem[8'h40] !== 32'hABCD_0000) begin errors++; $display("FAIL b2b_mem: got %h want abcd0000", mem[8'h40]); end
        next_cycle();
    endtask

    task automatic test_reset_mid_rd();
        int we0;
        preload(32'h140, 32'h5566_7788);
        we0 = we_cnt;
        drive(1'b1, 1'b0, F3_SB, 32'h141, 32'h0000_0099);
        next_cycle();
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_write_bh !== 1'b0) begin errors++; $display("FAIL rstrd_bh: got %0b want 0", bus.mem_write_bh); end
        checks++; if (bus.mem_re !== 1'b0) begin errors++; $display("FAIL rstrd_re: got %0b want 0", bus.mem_re); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rstrd_we: got %0b want 0", bus.mem_we); end
        idle_inputs();
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        checks++; if (we_cnt !== we0) begin errors++; $display("FAIL rstrd_no_write: got %0d writes want %0d", we_cnt, we0); end
        checks++; if (mem[8'h50] !== 32'h5566_7788) begin errors++; $display("FAIL rstrd_mem_kept: got %h want 55667788", mem[8'h50]); end
        drive(1'b1, 1'b0, F3_SB, 32'h141, 32'h0000_0099);
        next_cycle();
        next_cycle();
        #2;
        checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL rstrd_retry_we: got %0b want 1", bus.mem_we); end
        checks++; if (bus.mem_wdata !== 32'h5566_9988) begin errors++; $display("FAIL rstrd_retry_wdata: got %h want 55669988", bus.mem_wdata); end
        next_cycle();
        idle_inputs();
        #2;
        checks++; if (mem[8'h50] !== 32'h5566_9988) begin errors++; $display("FAIL rstrd_retry_mem: got %h want 55669988", mem[8'h50]); end
        next_cycle();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sb();
        test_sh();
        test_sw();
        test_load();
        test_back_to_back();
        test_reset_mid_rd();
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL re_we_exclusive: got %0d overlaps want 0", both_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_rmw_unit.md
# store_rmw_unit

Memory-stage store sequencer for the RV32I no-trap pipeline. The data memory is word-wide with no byte enables. This block therefore turns every SB/SH into a read-modify-write of the containing word, while SW and loads pass straight through. During the read-modify-write it raises `mem_write_bh`, the stall request the hazard unit consumes. The hazard unit freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB, so the store's EX/MEM operands stay stable for the whole sequence.

## Interface
- `ADDR_W`, default 32: byte-address width. Data width is fixed at 32.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `EX_MEM_memwrite`  in  1  store in MEM stage
- `EX_MEM_memread`  in  1  load in MEM stage
- `EX_MEM_funct3`  in  3  store width: 000 SB, 001 SH, 010 SW; other values are treated as SW
- `EX_MEM_addr`  in  ADDR_W  byte address (ALU result)
- `EX_MEM_wdata`  in  32  rs2 store data
- `mem_rdata`  in  32  data-memory read word; synchronous, valid the cycle after `mem_re`
- `mem_addr`  out  ADDR_W  word-aligned address, equal to `{EX_MEM_addr[ADDR_W-1:2], 2'b00}`
- `mem_re`  out  1  memory read strobe
- `mem_we`  out  1  memory write strobe
- `mem_wdata`  out  32  word to write
- `mem_write_bh`  out  1  stall request to the hazard unit

## Operation
- `req_bh` = `EX_MEM_memwrite` & (funct3 = SB or SH).
- FSM states: IDLE, RD, WR.
- **IDLE**
  - If `req_bh`: `mem_re`=1, `mem_write_bh`=1, go to RD.
  - Else if `EX_MEM_memwrite` (SW): `mem_we`=1, `mem_wdata`=`EX_MEM_wdata`, stay in IDLE.
  - Else: `mem_re`=`EX_MEM_memread`, stay in IDLE.
- **RD**
  - `mem_write_bh`=1, `mem_re`=0.
  - Register `wbuf` <= merge(`mem_rdata`, `EX_MEM_wdata`, funct3, addr[1:0]).
  - Go to WR.
- **WR**
  - `mem_we`=1, `mem_wdata`=`wbuf`, `mem_write_bh`=0.
  - Go to IDLE unconditionally.
  - The request still present this cycle is the same store. It must not retrigger the sequence.
- **Merge rules**
  - SB replaces byte lane addr[1:0] with `wdata[7:0]`.
  - SH replaces halfword lane addr[1] with `wdata[15:0]`.
  - addr[0] is ignored for SH; no misalignment trap.
  - Untouched lanes keep the bytes read from memory.
- `mem_addr` is driven from `EX_MEM_addr` in every state.
- **Reset**
  - Asynchronous reset forces IDLE and clears `wbuf` to 0.
  - While `rst_n`=0, `mem_re`, `mem_we` and `mem_write_bh` are forced to 0.
  - Reset during RD or WR abandons the store. No partial write occurs unless the WR-cycle edge has already passed.

## Timing
- Reset values: `mem_re`=0, `mem_we`=0, `mem_write_bh`=0, `mem_wdata`=0, state IDLE.
- SW and loads need no extra cycles.
- SB/SH occupy 3 cycles (IDLE issue, RD, WR), which is 2 stall cycles. `mem_write_bh` is high in cycles 0 and 1.
- `mem_write_bh` is combinational from state and `req_bh`, so the pipeline freezes in the same cycle the store reaches MEM.
- The pipeline advances at the end of WR, and the next instruction is evaluated in IDLE.
- Back-to-back SB, SB: the second store's IDLE/issue cycle immediately follows the first store's WR, with no gap.
- `mem_re` and `mem_we` are never high in the same cycle.

## Structure
- Shared package `rv32i_pkg` holds:
  - funct3 constants `F3_SB`, `F3_SH`, `F3_SW`;
  - the state encoding `IDLE`/`RD`/`WR`.
- Sub-module `byte_merge` is purely combinational: inputs old word, new data, funct3, addr[1:0]; output is the merged word.
- The FSM, `wbuf` and the output decode live in `store_rmw_unit`.

## Test plan
- **SB at addr 0x103, wdata 0xAABBCC5A, memory word 0x11223344:** `mem_write_bh` is 1,1,0 over 3 cycles; `mem_re` pulses in cycle 0; the WR cycle writes 0x5A223344 to 0x100.
- **SH at addr 0x202, wdata 0x0000BEEF, memory word 0xDEADC0DE:** writes 0xBEEFC0DE. Repeating at 0x201 gives 0xDEADBEEF, because addr[0] is ignored.
- **SW at 0x300, wdata 0x12345678:** `mem_we`=1 in the same cycle, `mem_write_bh` never asserts, and the FSM stays in IDLE.
- **Back-to-back SB 0x103 then SB 0x102 to the same word 0x00000000:** the final word is 0xAB_CD_0000 with byte 3 = 0xAB and byte 2 = 0xCD. This proves the second read sees the first write.
- **Reset asserted during RD:** outputs drop to 0 immediately, no `mem_we` occurs, the memory word is unchanged, and after release a new SB completes normally.
- **Load in MEM during IDLE:** `mem_re` is 1 in the same cycle and the stall stays 0.
